nvram_hiscore_ctrl: RTL

Arbiter for the game's battery-backed CMOS nibble RAM (high-score/settings store), sitting between the Williams-2 board CPU bus and the HPS ioctl file interface in the top level. It normally passes the CPU straight through to the RAM. When the HPS starts an NVRAM load (download) or save (upload) session, it pauses the CPU with a request/acknowledge handshake and transfers RAM ownership to the HPS. It then returns ownership to the CPU when the session ends. It also tracks whether the CPU has modified the RAM since the last save or load.

---
 rtl/nvram_hiscore_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/nvram_hiscore_ctrl.sv
// nvram_hiscore_ctrl: arbitrates the CMOS nibble RAM between the CPU and HPS ioctl load/save sessions.
// Ports: clk_sys/reset_n clock and async active-low reset; cpu_* CPU RAM port and pause handshake;
// ioctl_* HPS file interface; ram_* RAM port (1-cycle read latency); nvram_dirty, ack_timeout, busy status.
`timescale 1ns/1ps
module nvram_hiscore_ctrl #(
    parameter int AW          = 10,
    parameter int DW          = 4,
    parameter int IOCTL_IDX   = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_we,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_pause,
    input  logic          cpu_pause_ack,
    input  logic          ioctl_download,
    input  logic          ioctl_upload,
    input  logic [15:0]   ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ioctl_wr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout,
    output logic          nvram_dirty,
    output logic          ack_timeout,
    output logic          busy
);
    localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, REQ, GRANT, DONE} state_t;
    state_t        state, state_nx;
    logic          sess, sess_q, start, flag, is_dl, granted, in_range, cpu_owns;
    logic          oor_q, oor_d, we_q, timed_out;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [7:0]    rd_q;
    assign sess      = ioctl_download | ioctl_upload;
    assign start     = (ioctl_index == 16'(IOCTL_IDX)) & sess & ~sess_q;
    assign flag      = is_dl ? ioctl_download : ioctl_upload;
    assign in_range  = (ioctl_addr >> AW) == '0;
    assign timed_out = cnt == CW'(ACK_TIMEOUT);
    assign cpu_owns  = (state == IDLE) || (state == REQ);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = start ? REQ : IDLE;
            REQ:   state_nx = !flag ? DONE : (cpu_pause_ack || timed_out) ? GRANT : REQ;
            GRANT: state_nx = !flag ? DONE : GRANT;
            DONE:  state_nx = IDLE;
        endcase
    end
    // sess_q resets high so a session still active across reset never looks like a fresh edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sess_q      <= 1'b1;
            is_dl       <= 1'b0;
            granted     <= 1'b0;
            cnt         <= '0;
            ack_timeout <= 1'b0;
            nvram_dirty <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            oor_q       <= 1'b0;
            oor_d       <= 1'b0;
            rd_q        <= 8'h00;
        end else begin
            state  <= state_nx;
            sess_q <= sess;
            cnt    <= (state == REQ) ? cnt + 1'b1 : '0;
            oor_q  <= ~in_range;
            oor_d  <= oor_q;
            we_q   <= (state == GRANT) && is_dl && ioctl_wr && in_range;
            if (state == IDLE && start) begin
                is_dl   <= ioctl_download;
                granted <= 1'b0;
            end
            if (state == GRANT)
                granted <= 1'b1;
            if (state == REQ && flag && !cpu_pause_ack && timed_out)
                ack_timeout <= 1'b1;
            if (cpu_owns && cpu_we)
                nvram_dirty <= 1'b1;
            else if (state == DONE && granted)
                nvram_dirty <= 1'b0;
            if (state == GRANT && (is_dl ? ioctl_wr && in_range : 1'b1)) begin
                addr_q <= AW'(ioctl_addr);
                din_q  <= is_dl ? DW'(ioctl_dout) : din_q;
            end
            // Out-of-range flag is delayed twice to line up with the RAM read of that address.
            if (state == GRANT && !is_dl)
                rd_q <= oor_d ? 8'h00 : 8'(ram_dout);
        end
    end
    assign ram_addr   = cpu_owns ? cpu_addr : addr_q;
    assign ram_din    = cpu_owns ? cpu_din : din_q;
    assign ram_we     = reset_n & (cpu_owns ? cpu_we : (state == GRANT) & we_q);
    assign cpu_dout   = ram_dout;
    assign cpu_pause  = (state == REQ) || (state == GRANT);
    assign ioctl_wait = state == REQ;
    assign busy       = state != IDLE;
    assign ioctl_din  = rd_q;
endmodule
